// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with register file, immediate generation,
// control decode, branch resolution, hazard/stall control and the ID/EX register.
// Optional feature macro: WB_BYPASS_EN (writeback data bypasses the register
// file read in the same cycle). Without it the stored (pre-write) value is read.

`ifndef NUM_REG
`define NUM_REG 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IMM_SEL_WIDTH
`define IMM_SEL_WIDTH 3
`endif

module id_stage_pipe #(
  parameter int NUM_REG        = `NUM_REG,
  parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
  parameter int REG_WIDTH      = `REG_WIDTH,
  parameter int PC_WIDTH       = `PC_WIDTH,
  parameter int INST_WIDTH     = `INST_WIDTH,
  parameter int IMM_SEL_WIDTH  = `IMM_SEL_WIDTH,
  parameter int LOAD_BR_STALL  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      IF_ID_valid,
  input  logic [PC_WIDTH-1:0]       IF_ID_pc,
  input  logic [INST_WIDTH-1:0]     IF_ID_inst,
  input  logic                      MEM_WB_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
  input  logic [REG_WIDTH-1:0]      WB_data,
  input  logic [1:0]                forward_sel1,
  input  logic [1:0]                forward_sel2,
  input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]      DMEM_data_out,
  input  logic                      hold_in,
  input  logic                      flush_in,
  output logic [PC_WIDTH-1:0]       pc_imm,
  output logic                      pc_sel,
  output logic                      stall_out,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_valid,
  output logic [PC_WIDTH-1:0]       ID_EX_pc,
  output logic [REG_WIDTH-1:0]      ID_EX_rs1_data,
  output logic [REG_WIDTH-1:0]      ID_EX_rs2_data,
  output logic [REG_WIDTH-1:0]      ID_EX_imm,
  output logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  output logic                      ID_EX_reg_write_en,
  output logic                      ID_EX_mem_write_en,
  output logic                      ID_EX_mem_read,
  output logic [2:0]                ID_EX_alu_sel,
  output logic                      ID_EX_ASel,
  output logic                      ID_EX_BSel,
  output logic [1:0]                ID_EX_wb_sel
);

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [IMM_SEL_WIDTH-1:0] IMM_I = IMM_SEL_WIDTH'(0), IMM_S = IMM_SEL_WIDTH'(1),
                                       IMM_B = IMM_SEL_WIDTH'(2), IMM_U = IMM_SEL_WIDTH'(3),
                                       IMM_J = IMM_SEL_WIDTH'(4);
  // ALU codes: SLT/SLTU issue as SUB and EX derives the flag from the difference.
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                         ALU_XOR = 3'd4, ALU_SLL = 3'd5, ALU_SRL = 3'd6, ALU_SRA = 3'd7;
  // wb_sel: 00 ALU result, 01 load data, 10 pc+4

  typedef struct packed {
    logic                      valid;
    logic [PC_WIDTH-1:0]       pc;
    logic [REG_WIDTH-1:0]      rs1;
    logic [REG_WIDTH-1:0]      rs2;
    logic [REG_WIDTH-1:0]      imm;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rw;
    logic                      mw;
    logic                      mr;
    logic [2:0]                alu;
    logic                      asel;
    logic                      bsel;
    logic [1:0]                wb;
  } id_ex_t;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [REG_ADDR_WIDTH-1:0] rs1_idx, rs2_idx;
  logic [REG_WIDTH-1:0] rf_q [NUM_REG];
  logic [REG_WIDTH-1:0] rf_rs1, rf_rs2, fwd1, fwd2, imm_val;
  logic [31:0] imm_raw;
  logic [IMM_SEL_WIDTH-1:0] imm_sel;
  logic is_br, is_jal, is_jalr, is_lui, rs1_used, rs2_used, br_cond, taken;
  logic dep, cnt_stall;
  logic [1:0] need, stall_cnt_q, stall_cnt_d;
  id_ex_t id_ex_d, id_ex_q;

  assign inst    = IF_ID_inst[31:0];
  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign rs1_idx = REG_ADDR_WIDTH'(inst[19:15]);
  assign rs2_idx = REG_ADDR_WIDTH'(inst[24:20]);
  assign is_br   = (opcode == OP_BR);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign is_lui  = (opcode == OP_LUI);
  assign rs1_used = !(is_lui || is_jal || opcode == OP_AUIPC);
  assign rs2_used = (opcode == OP_R) || (opcode == OP_ST) || is_br;

  // Register file: x0 never written, written at the edge closing writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REG; i++) rf_q[i] <= '0;
    end else if (MEM_WB_reg_wr_en && MEM_WB_rd != '0) begin
      rf_q[MEM_WB_rd] <= WB_data;
    end
  end

  // Register file read ports, optional same-cycle writeback bypass
  always_comb begin
    rf_rs1 = rf_q[rs1_idx];
    rf_rs2 = rf_q[rs2_idx];
`ifdef WB_BYPASS_EN
    if (MEM_WB_reg_wr_en && MEM_WB_rd != '0 && MEM_WB_rd == rs1_idx) rf_rs1 = WB_data;
    if (MEM_WB_reg_wr_en && MEM_WB_rd != '0 && MEM_WB_rd == rs2_idx) rf_rs2 = WB_data;
`endif
    if (rs1_idx == '0) rf_rs1 = '0;
    if (rs2_idx == '0) rf_rs2 = '0;
  end

  // Operand forwarding muxes
  always_comb begin
    case (forward_sel1)
      2'b01:   fwd1 = EX_MEM_alu_out;
      2'b10:   fwd1 = DMEM_data_out;
      default: fwd1 = rf_rs1;
    endcase
    case (forward_sel2)
      2'b01:   fwd2 = EX_MEM_alu_out;
      2'b10:   fwd2 = DMEM_data_out;
      default: fwd2 = rf_rs2;
    endcase
  end

  // Immediate generation
  always_comb begin
    case (imm_sel)
      IMM_S:   imm_raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm_raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm_raw = {inst[31:12], 12'b0};
      IMM_J:   imm_raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm_raw = {{20{inst[31]}}, inst[31:20]};
    endcase
    imm_val = REG_WIDTH'($signed(imm_raw));
  end

  // Control decode into the ID/EX next value; enables only for a real instruction
  always_comb begin
    id_ex_d       = '0;
    imm_sel       = IMM_I;
    id_ex_d.valid = IF_ID_valid;
    id_ex_d.pc    = IF_ID_pc;
    id_ex_d.rd    = REG_ADDR_WIDTH'(inst[11:7]);
    case (opcode)
      OP_R, OP_I: begin
        id_ex_d.rw   = 1'b1;
        id_ex_d.bsel = (opcode == OP_I);
        case (funct3)
          3'b000:  id_ex_d.alu = (opcode == OP_R && inst[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  id_ex_d.alu = ALU_SLL;
          3'b100:  id_ex_d.alu = ALU_XOR;
          3'b101:  id_ex_d.alu = inst[30] ? ALU_SRA : ALU_SRL;
          3'b110:  id_ex_d.alu = ALU_OR;
          3'b111:  id_ex_d.alu = ALU_AND;
          default: id_ex_d.alu = ALU_SUB;
        endcase
      end
      OP_LD:    begin id_ex_d.rw = 1'b1; id_ex_d.mr = 1'b1; id_ex_d.bsel = 1'b1; id_ex_d.wb = 2'b01; end
      OP_ST:    begin imm_sel = IMM_S; id_ex_d.mw = 1'b1; id_ex_d.bsel = 1'b1; end
      OP_BR:    begin imm_sel = IMM_B; id_ex_d.asel = 1'b1; id_ex_d.bsel = 1'b1; end
      OP_JAL:   begin imm_sel = IMM_J; id_ex_d.rw = 1'b1; id_ex_d.asel = 1'b1; id_ex_d.bsel = 1'b1; id_ex_d.wb = 2'b10; end
      OP_JALR:  begin id_ex_d.rw = 1'b1; id_ex_d.bsel = 1'b1; id_ex_d.wb = 2'b10; end
      OP_LUI:   begin imm_sel = IMM_U; id_ex_d.rw = 1'b1; id_ex_d.bsel = 1'b1; end
      OP_AUIPC: begin imm_sel = IMM_U; id_ex_d.rw = 1'b1; id_ex_d.asel = 1'b1; id_ex_d.bsel = 1'b1; end
      default:  ;
    endcase
    // LUI computes 0 + imm in EX, so operand A is forced to zero
    id_ex_d.rs1 = is_lui ? '0 : fwd1;
    id_ex_d.rs2 = fwd2;
    id_ex_d.imm = imm_val;
    id_ex_d.rw  = id_ex_d.rw & IF_ID_valid;
    id_ex_d.mw  = id_ex_d.mw & IF_ID_valid;
    id_ex_d.mr  = id_ex_d.mr & IF_ID_valid;
  end

  // Branch comparison on forwarded operands and redirect qualification
  always_comb begin
    case (funct3)
      3'b000:  br_cond = (fwd1 == fwd2);
      3'b001:  br_cond = (fwd1 != fwd2);
      3'b100:  br_cond = ($signed(fwd1) < $signed(fwd2));
      3'b101:  br_cond = ($signed(fwd1) >= $signed(fwd2));
      3'b110:  br_cond = (fwd1 < fwd2);
      3'b111:  br_cond = (fwd1 >= fwd2);
      default: br_cond = 1'b0;
    endcase
    taken = (is_br && br_cond) || is_jal || is_jalr;
  end

  assign pc_imm      = IF_ID_pc + PC_WIDTH'(imm_val);
  assign pc_sel      = taken && IF_ID_valid && !stall_out && !flush_in && !reset;
  assign IF_ID_flush = pc_sel;

  // Hazard detection: stall length needed against the instruction in ID/EX
  always_comb begin
    dep = (rs1_used && rs1_idx != '0 && rs1_idx == id_ex_q.rd) ||
          (rs2_used && rs2_idx != '0 && rs2_idx == id_ex_q.rd);
    need = 2'd0;
    if (dep && id_ex_q.mr)
      need = (is_br || is_jalr) ? 2'(LOAD_BR_STALL) : 2'd1;
    else if (dep && id_ex_q.rw && (is_br || is_jalr))
      need = 2'd1;
    cnt_stall = 1'b0;
    stall_cnt_d = 2'd0;
    if (stall_cnt_q != 2'd0) begin
      cnt_stall   = 1'b1;
      stall_cnt_d = stall_cnt_q - 2'd1;
    end else if (IF_ID_valid && need != 2'd0) begin
      cnt_stall   = 1'b1;
      stall_cnt_d = need - 2'd1;
    end
  end

  assign stall_out = cnt_stall | hold_in;

  // ID/EX register and stall counter: flush > hold > counter bubble > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_q     <= '0;
      stall_cnt_q <= 2'd0;
    end else if (flush_in) begin
      id_ex_q     <= '0;
      stall_cnt_q <= 2'd0;
    end else if (!hold_in) begin
      id_ex_q     <= cnt_stall ? '0 : id_ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ID_EX_valid        = id_ex_q.valid;
  assign ID_EX_pc           = id_ex_q.pc;
  assign ID_EX_rs1_data     = id_ex_q.rs1;
  assign ID_EX_rs2_data     = id_ex_q.rs2;
  assign ID_EX_imm          = id_ex_q.imm;
  assign ID_EX_rd           = id_ex_q.rd;
  assign ID_EX_reg_write_en = id_ex_q.rw;
  assign ID_EX_mem_write_en = id_ex_q.mw;
  assign ID_EX_mem_read     = id_ex_q.mr;
  assign ID_EX_alu_sel      = id_ex_q.alu;
  assign ID_EX_ASel         = id_ex_q.asel;
  assign ID_EX_BSel         = id_ex_q.bsel;
  assign ID_EX_wb_sel       = id_ex_q.wb;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: vector table plus hand sequences for
// hold/flush, hold+stall, reset mid-stall and writeback read timing.
module tb_id_stage_pipe;

  localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3, x1, x2
  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5, 0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00128333; // add  x6, x5, x1
  localparam logic [31:0] I_BEQ   = 32'h00028863; // beq  x5, x0, +16
  localparam logic [31:0] I_JAL   = 32'hFF9FF0EF; // jal  x1, -8
  localparam logic [31:0] I_BNE   = 32'h00209463; // bne  x1, x2, +8
  localparam logic [31:0] I_SW    = 32'h0020A223; // sw   x2, 4(x1)
  localparam logic [31:0] I_ADD7  = 32'h000203B3; // add  x7, x4, x0

  logic        clk = 1'b0, reset;
  logic        IF_ID_valid, MEM_WB_reg_wr_en, hold_in, flush_in;
  logic [31:0] IF_ID_pc, IF_ID_inst, WB_data, EX_MEM_alu_out, DMEM_data_out;
  logic [4:0]  MEM_WB_rd;
  logic [1:0]  forward_sel1, forward_sel2;
  logic [31:0] pc_imm, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic        pc_sel, stall_out, IF_ID_flush, ID_EX_valid;
  logic [4:0]  ID_EX_rd;
  logic        ID_EX_reg_write_en, ID_EX_mem_write_en, ID_EX_mem_read, ID_EX_ASel, ID_EX_BSel;
  logic [2:0]  ID_EX_alu_sel;
  logic [1:0]  ID_EX_wb_sel;

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk(clk), .reset(reset), .IF_ID_valid(IF_ID_valid), .IF_ID_pc(IF_ID_pc),
    .IF_ID_inst(IF_ID_inst), .MEM_WB_reg_wr_en(MEM_WB_reg_wr_en), .MEM_WB_rd(MEM_WB_rd),
    .WB_data(WB_data), .forward_sel1(forward_sel1), .forward_sel2(forward_sel2),
    .EX_MEM_alu_out(EX_MEM_alu_out), .DMEM_data_out(DMEM_data_out), .hold_in(hold_in),
    .flush_in(flush_in), .pc_imm(pc_imm), .pc_sel(pc_sel), .stall_out(stall_out),
    .IF_ID_flush(IF_ID_flush), .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rd(ID_EX_rd), .ID_EX_reg_write_en(ID_EX_reg_write_en),
    .ID_EX_mem_write_en(ID_EX_mem_write_en), .ID_EX_mem_read(ID_EX_mem_read),
    .ID_EX_alu_sel(ID_EX_alu_sel), .ID_EX_ASel(ID_EX_ASel), .ID_EX_BSel(ID_EX_BSel),
    .ID_EX_wb_sel(ID_EX_wb_sel)
  );

  typedef struct {
    logic        valid;
    logic [31:0] inst, pc;
    logic [1:0]  f1, f2;
    logic [31:0] exv, dmv;
    logic        e_stall, e_psel;
    logic [31:0] e_pcimm;
    logic        e_valid;
    logic [31:0] e_rs1, e_rs2, e_imm;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw;
  } vec_t;

  vec_t vecs[16];
  int n_cmp = 0, n_err = 0;
  int stalls_seen;
  logic [31:0] exp_byp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [1:0] f1, input logic [1:0] f2,
                        input logic [31:0] exv, input logic [31:0] dmv,
                        input logic h, input logic fl);
    IF_ID_valid = v; IF_ID_inst = inst; IF_ID_pc = pc;
    forward_sel1 = f1; forward_sel2 = f2;
    EX_MEM_alu_out = exv; DMEM_data_out = dmv;
    hold_in = h; flush_in = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_write(input logic [4:0] idx, input logic [31:0] data);
    MEM_WB_reg_wr_en = 1'b1; MEM_WB_rd = idx; WB_data = data;
    tick();
    MEM_WB_reg_wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //        v  inst    pc          f1 f2 exv     dmv    st ps pcimm         vl rs1     rs2     imm           rd  rw mr mw
    vecs[0]  = '{1, I_ADD3, 32'h100, 0, 0, 0,      0,     0, 0, 32'h102,      1, 5,      7,      2,            3,  1, 0, 0};
    vecs[1]  = '{1, I_ADD3, 32'h104, 1, 2, 'h111,  'h222, 0, 0, 32'h106,      1, 'h111,  'h222,  2,            3,  1, 0, 0};
    vecs[2]  = '{1, I_ADD3, 32'h108, 3, 3, 'h111,  'h222, 0, 0, 32'h10A,      1, 5,      7,      2,            3,  1, 0, 0};
    vecs[3]  = '{1, I_LW5,  32'h10C, 0, 0, 0,      0,     0, 0, 32'h10C,      1, 5,      0,      0,            5,  1, 1, 0};
    vecs[4]  = '{1, I_ADD6, 32'h110, 0, 0, 0,      0,     1, 0, 32'h111,      0, 0,      0,      0,            0,  0, 0, 0};
    vecs[5]  = '{1, I_ADD6, 32'h110, 0, 0, 0,      0,     0, 0, 32'h111,      1, 0,      5,      1,            6,  1, 0, 0};
    vecs[6]  = '{1, I_LW5,  32'h114, 0, 0, 0,      0,     0, 0, 32'h114,      1, 5,      0,      0,            5,  1, 1, 0};
    vecs[7]  = '{1, I_BEQ,  32'h118, 0, 0, 0,      0,     1, 0, 32'h128,      0, 0,      0,      0,            0,  0, 0, 0};
    vecs[8]  = '{1, I_BEQ,  32'h118, 0, 0, 0,      0,     1, 0, 32'h128,      0, 0,      0,      0,            0,  0, 0, 0};
    vecs[9]  = '{1, I_BEQ,  32'h118, 2, 0, 0,      0,     0, 1, 32'h128,      1, 0,      0,      16,           16, 0, 0, 0};
    vecs[10] = '{1, I_JAL,  32'h4,   0, 0, 0,      0,     0, 1, 32'hFFFFFFFC, 1, 0,      0,      32'hFFFFFFF8, 1,  1, 0, 0};
    vecs[11] = '{1, I_BNE,  32'h200, 0, 0, 0,      0,     1, 0, 32'h208,      0, 0,      0,      0,            0,  0, 0, 0};
    vecs[12] = '{1, I_BNE,  32'h200, 0, 0, 0,      0,     0, 1, 32'h208,      1, 5,      7,      8,            8,  0, 0, 0};
    vecs[13] = '{1, I_SW,   32'h300, 0, 0, 0,      0,     0, 0, 32'h304,      1, 5,      7,      4,            4,  0, 0, 1};
    vecs[14] = '{1, I_BNE,  32'h400, 1, 0, 7,      0,     0, 0, 32'h408,      1, 7,      7,      8,            8,  0, 0, 0};
    vecs[15] = '{0, I_ADD3, 32'h500, 0, 0, 0,      0,     0, 0, 32'h502,      0, 5,      7,      2,            3,  0, 0, 0};

    reset = 1'b1;
    MEM_WB_reg_wr_en = 1'b0; MEM_WB_rd = '0; WB_data = '0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rst.valid", 32'(ID_EX_valid), 0);
    chk("rst.stall", 32'(stall_out), 0);
    chk("rst.rw", 32'(ID_EX_reg_write_en), 0);
    reset = 1'b0;

    rf_write(5'd1, 32'd5);
    rf_write(5'd2, 32'd7);

    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].valid, vecs[i].inst, vecs[i].pc, vecs[i].f1, vecs[i].f2,
             vecs[i].exv, vecs[i].dmv, 0, 0);
      @(negedge clk);
      chk($sformatf("v%0d.stall", i), 32'(stall_out), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d.pc_sel", i), 32'(pc_sel), 32'(vecs[i].e_psel));
      chk($sformatf("v%0d.if_id_flush", i), 32'(IF_ID_flush), 32'(vecs[i].e_psel));
      chk($sformatf("v%0d.pc_imm", i), pc_imm, vecs[i].e_pcimm);
      tick();
      chk($sformatf("v%0d.valid", i), 32'(ID_EX_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d.rs1", i), ID_EX_rs1_data, vecs[i].e_rs1);
      chk($sformatf("v%0d.rs2", i), ID_EX_rs2_data, vecs[i].e_rs2);
      chk($sformatf("v%0d.imm", i), ID_EX_imm, vecs[i].e_imm);
      chk($sformatf("v%0d.rd", i), 32'(ID_EX_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d.rw", i), 32'(ID_EX_reg_write_en), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d.mr", i), 32'(ID_EX_mem_read), 32'(vecs[i].e_mr));
      chk($sformatf("v%0d.mw", i), 32'(ID_EX_mem_write_en), 32'(vecs[i].e_mw));
    end

    // hold for 3 cycles with a jump waiting in ID, then flush during hold
    set_in(1, I_ADD3, 32'h600, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1, I_JAL, 32'h604, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk($sformatf("hold%0d.stall", k), 32'(stall_out), 1);
      chk($sformatf("hold%0d.pc_sel", k), 32'(pc_sel), 0);
      tick();
      chk($sformatf("hold%0d.valid", k), 32'(ID_EX_valid), 1);
      chk($sformatf("hold%0d.rs1", k), ID_EX_rs1_data, 5);
      chk($sformatf("hold%0d.rd", k), 32'(ID_EX_rd), 3);
      chk($sformatf("hold%0d.pc", k), ID_EX_pc, 32'h600);
    end
    set_in(1, I_JAL, 32'h604, 0, 0, 0, 0, 1, 1);
    tick();
    chk("holdflush.valid", 32'(ID_EX_valid), 0);
    chk("holdflush.rw", 32'(ID_EX_reg_write_en), 0);

    // hold overlapping a load-use stall: 2 hold cycles + 1 counter cycle
    set_in(1, I_LW5, 32'h700, 0, 0, 0, 0, 0, 0);
    tick();
    stalls_seen = 0;
    for (int k = 0; k < 5; k++) begin
      set_in(1, I_ADD6, 32'h704, 0, 0, 0, 0, (k < 2), 0);
      @(negedge clk);
      if (stall_out) stalls_seen++;
      tick();
      if (k < 2) chk($sformatf("hs%0d.mr_held", k), 32'(ID_EX_mem_read), 1);
      if (k == 2) chk("hs.bubble", 32'(ID_EX_valid), 0);
      if (k == 3) chk("hs.issue_rd", 32'(ID_EX_rd), 6);
    end
    chk("hs.total_stall", 32'(stalls_seen), 3);

    // reset pulsed while the branch-after-load counter is mid-stall
    set_in(1, I_LW5, 32'h800, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, I_BEQ, 32'h804, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rm.stall_pre", 32'(stall_out), 1);
    tick();
    reset = 1'b1;
    #1;
    chk("rm.valid", 32'(ID_EX_valid), 0);
    chk("rm.mr", 32'(ID_EX_mem_read), 0);
    chk("rm.rd", 32'(ID_EX_rd), 0);
    chk("rm.stall", 32'(stall_out), 0);
    chk("rm.pc_sel", 32'(pc_sel), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rm.stall_after", 32'(stall_out), 0);
    chk("rm.pc_sel_after", 32'(pc_sel), 1);
    tick();

    // writeback and read of x4 in the same cycle
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rf_write(5'd4, 32'h33);
    set_in(1, I_ADD7, 32'h900, 0, 0, 0, 0, 0, 0);
    rf_write(5'd4, 32'hA5);
`ifdef WB_BYPASS_EN
    exp_byp = 32'hA5;
`else
    exp_byp = 32'h33;
`endif
    chk("wb.same_cycle", ID_EX_rs1_data, exp_byp);
    tick();
    chk("wb.next_cycle", ID_EX_rs1_data, 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
